pp_pipeline_accel_mat2axi_scalar_queue: RTL and testbench
=========================================================

PP_PIPELINE_ACCEL_MAT2AXI_SCALAR_QUEUE -- requirements
Module: pp_pipeline_accel_mat2axi_scalar_queue

Interface
REQ-001 Parameter W, default 19: bit width of each scalar channel; SHALL be >= 1.
REQ-002 Parameter NCH, default 2: number of scalar channels captured per task; SHALL be >= 1.
REQ-003 Parameter DEPTH, default 2: number of tasks buffered; SHALL be >= 1 and need not be a power of two.
REQ-004 Parameter ROUND_SHIFT, default 0: 0 = pass-through; S > 0 = each channel returned as ceil(x / 2^S); SHALL be < W.
REQ-005 Port ap_clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port ap_rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port ap_start, input, 1: producer offers a task.
REQ-008 Port ap_ready, output, 1: task accepted this cycle.
REQ-009 Port ap_done, output, 1: head task result valid.
REQ-010 Port ap_continue, input, 1: consumer takes the head result.
REQ-011 Port ap_idle, output, 1: no task offered and buffer empty.
REQ-012 Port scalar_in, input, NCH*W: channel k at bits [k*W +: W].
REQ-013 Port ap_return, output, NCH*W: head result, same channel packing.
REQ-014 Port occupancy, output, clog2(DEPTH+1): number of buffered tasks.

Function
REQ-015 Push: ap_ready SHALL equal ap_start AND (occupancy < DEPTH), combinationally; a task is captured when ap_ready is 1.
REQ-016 ap_ready SHALL NOT depend on ap_continue; a full buffer with a simultaneous pop still refuses the push that cycle.
REQ-017 Transform: with ROUND_SHIFT = 0, each stored channel SHALL equal its input; with S > 0, each channel SHALL be (x + 2^S - 1) >> S, computed in W+1 bits with no overflow, zero-extended to W.
REQ-018 Latency: a task pushed in cycle N SHALL be visible on ap_return with ap_done = 1 in cycle N+1 at the earliest; no same-cycle bypass.
REQ-019 ap_done SHALL equal (occupancy != 0), driven from registered state only.
REQ-020 ap_return SHALL present the oldest buffered task while ap_done = 1, and SHALL be all-zero while occupancy = 0.
REQ-021 Pop: ap_continue = 1 with ap_done = 1 SHALL remove the head at the clock edge; ap_continue with occupancy = 0 SHALL have no effect.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged; at occupancy 1, the head SHALL become the newly pushed task in the next cycle.
REQ-023 Read and write pointers SHALL wrap from DEPTH-1 to 0; results SHALL leave in strict push order.
REQ-024 ap_idle SHALL equal (ap_start = 0) AND (occupancy = 0).
REQ-025 Holding ap_start high with ap_ready low SHALL NOT capture data or alter state; scalar_in is sampled only on accept.
REQ-026 occupancy SHALL never exceed DEPTH and never underflow.

Reset
REQ-027 ap_rst = 1 SHALL asynchronously clear occupancy and both pointers to 0, making ap_done = 0 and ap_return = 0 without waiting for a clock edge.
REQ-028 Reset mid-operation SHALL discard all buffered tasks; a push presented during reset SHALL NOT be captured.
REQ-029 After reset deasserts, the first rising edge SHALL accept a push if ap_start = 1; no warm-up cycles.

Verification
REQ-030 Defaults, push scalar_in = {19'd7, 19'd300} with ap_continue = 0 -> next cycle: ap_done = 1, ap_return = {7, 300}, occupancy = 1; ap_ready stayed 1 during the push cycle.
REQ-031 DEPTH = 2: push A, B, then hold C with ap_continue = 0 -> ap_ready = 0 for C, occupancy = 2; assert ap_continue one cycle -> ap_return = B, and C is accepted on the following cycle.
REQ-032 DEPTH = 3: run 10 tasks with random start/continue stalls -> outputs in exact push order across pointer wrap; occupancy never > 3.
REQ-033 ROUND_SHIFT = 3, W = 19: inputs 0, 1, 8, 9, 19'h7FFFF -> outputs 0, 1, 1, 2, 19'h10000.
REQ-034 Occupancy 1, head X, push Y with ap_continue = 1 in the same cycle -> next cycle: occupancy = 1, ap_return = Y.
REQ-035 Occupancy 2, ap_rst pulsed high between clock edges -> ap_done = 0, ap_return = 0, and occupancy = 0 immediately; ap_idle = 1 if ap_start = 0.

Source files
------------

// File: rtl/pp_pipeline_accel_mat2axi_scalar_queue_if.sv
// Handshake and data bundle between a scalar producer/consumer and the scalar queue.
interface pp_pipeline_accel_mat2axi_scalar_queue_if #(
    parameter int unsigned W     = 19,
    parameter int unsigned NCH   = 2,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned DW = NCH * W;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_continue;
    logic          ap_idle;
    logic [DW-1:0] scalar_in;
    logic [DW-1:0] ap_return;
    logic [OW-1:0] occupancy;

    // Producer/consumer side.
    modport master (
        output ap_start, ap_continue, scalar_in,
        input  ap_ready, ap_done, ap_idle, ap_return, occupancy
    );

    // Queue side.
    modport slave (
        input  ap_start, ap_continue, scalar_in,
        output ap_ready, ap_done, ap_idle, ap_return, occupancy
    );
endinterface

// File: rtl/pp_pipeline_accel_mat2axi_scalar_queue.sv
// Small task FIFO: captures NCH scalar channels per accepted task, optionally
// applies a ceiling right-shift, and returns results in push order.
module pp_pipeline_accel_mat2axi_scalar_queue #(
    parameter int unsigned W           = 19,
    parameter int unsigned NCH         = 2,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned ROUND_SHIFT = 0
) (
    input  logic ap_clk,
    input  logic ap_rst,
    pp_pipeline_accel_mat2axi_scalar_queue_if.slave bus
);
    localparam int unsigned DW = NCH * W;
    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] count;
    logic [DW-1:0] xf;
    logic          push;
    logic          pop;

    // Accept depends only on registered occupancy, never on the consumer.
    assign push = bus.ap_start && (count < FULL);
    assign pop  = bus.ap_continue && (count != '0);

    // Per-channel transform applied on the way into storage.
    genvar k;
    for (k = 0; k < NCH; k++) begin : g_ch
        if (ROUND_SHIFT == 0) begin : g_pass
            assign xf[k*W +: W] = bus.scalar_in[k*W +: W];
        end else begin : g_round
            localparam logic [W:0] RND = {{(W + 1 - ROUND_SHIFT){1'b0}}, {ROUND_SHIFT{1'b1}}};
            logic [W:0] sum_c;
            // One extra bit keeps x + 2^S - 1 from overflowing.
            assign sum_c        = {1'b0, bus.scalar_in[k*W +: W]} + RND;
            assign xf[k*W +: W] = W'(sum_c >> ROUND_SHIFT);
        end
    end

    // Pointers and occupancy; wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents are don't-care until covered by occupancy.
    always_ff @(posedge ap_clk) begin
        if (push && !ap_rst) begin
            mem[wr_ptr] <= xf;
        end
    end

    assign bus.ap_ready  = push;
    assign bus.ap_done   = (count != '0);
    assign bus.ap_idle   = !bus.ap_start && (count == '0);
    assign bus.ap_return = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.occupancy = count;
endmodule

// File: tb/tb_pp_pipeline_accel_mat2axi_scalar_queue.sv
// Directed plus randomized bench for the scalar task queue, three configurations.
module tb_pp_pipeline_accel_mat2axi_scalar_queue;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    int checks   = 0;
    int failures = 0;

    pp_pipeline_accel_mat2axi_scalar_queue_if #(.W(19), .NCH(2), .DEPTH(2)) i0 ();
    pp_pipeline_accel_mat2axi_scalar_queue_if #(.W(19), .NCH(2), .DEPTH(3)) i3 ();
    pp_pipeline_accel_mat2axi_scalar_queue_if #(.W(19), .NCH(2), .DEPTH(2)) ir ();

    pp_pipeline_accel_mat2axi_scalar_queue #(.W(19), .NCH(2), .DEPTH(2), .ROUND_SHIFT(0)) dut0 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(i0));
    pp_pipeline_accel_mat2axi_scalar_queue #(.W(19), .NCH(2), .DEPTH(3), .ROUND_SHIFT(0)) dut3 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(i3));
    pp_pipeline_accel_mat2axi_scalar_queue #(.W(19), .NCH(2), .DEPTH(2), .ROUND_SHIFT(3)) dutr (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(ir));

    // Reference model: one queue of expected results per instance.
    logic [37:0] q0[$];
    logic [37:0] q3[$];
    logic [37:0] qr[$];
    logic        last_ready0;
    int          pops3 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ceiling division by 2^s per 19-bit channel.
    function automatic logic [37:0] xform(input logic [37:0] v, input int unsigned s);
        logic [37:0] r;
        longint unsigned x, d;
        r = '0;
        d = 64'd1 << s;
        for (int k = 0; k < 2; k++) begin
            x = 64'(v[k*19 +: 19]);
            r[k*19 +: 19] = 19'(x / d + ((x % d != 0) ? 64'd1 : 64'd0));
        end
        return r;
    endfunction

    // One clock: check combinational handshakes, advance the model, check state.
    task automatic cycle();
        logic pu0, po0, pu3, po3, pur, por;
        logic [37:0] in0, in3, inr;
        #2;
        chk("d0_ready", 64'(i0.ap_ready), 64'(i0.ap_start && q0.size() < 2));
        chk("d3_ready", 64'(i3.ap_ready), 64'(i3.ap_start && q3.size() < 3));
        chk("dr_ready", 64'(ir.ap_ready), 64'(ir.ap_start && qr.size() < 2));
        chk("d0_idle",  64'(i0.ap_idle),  64'(!i0.ap_start && q0.size() == 0));
        chk("d3_idle",  64'(i3.ap_idle),  64'(!i3.ap_start && q3.size() == 0));
        last_ready0 = i0.ap_ready;
        pu0 = i0.ap_start && q0.size() < 2;  po0 = i0.ap_continue && q0.size() > 0;
        pu3 = i3.ap_start && q3.size() < 3;  po3 = i3.ap_continue && q3.size() > 0;
        pur = ir.ap_start && qr.size() < 2;  por = ir.ap_continue && qr.size() > 0;
        in0 = i0.scalar_in; in3 = i3.scalar_in; inr = ir.scalar_in;
        @(posedge ap_clk);
        #1;
        if (po0) void'(q0.pop_front());
        if (pu0) q0.push_back(xform(in0, 0));
        if (po3) begin void'(q3.pop_front()); pops3++; end
        if (pu3) q3.push_back(xform(in3, 0));
        if (por) void'(qr.pop_front());
        if (pur) qr.push_back(xform(inr, 3));
        chk("d0_done", 64'(i0.ap_done), 64'(q0.size() != 0));
        chk("d0_occ",  64'(i0.occupancy), 64'(q0.size()));
        chk("d0_ret",  64'(i0.ap_return), 64'((q0.size() != 0) ? q0[0] : 38'd0));
        chk("d3_done", 64'(i3.ap_done), 64'(q3.size() != 0));
        chk("d3_occ",  64'(i3.occupancy), 64'(q3.size()));
        chk("d3_ret",  64'(i3.ap_return), 64'((q3.size() != 0) ? q3[0] : 38'd0));
        chk("dr_occ",  64'(ir.occupancy), 64'(qr.size()));
        chk("dr_ret",  64'(ir.ap_return), 64'((qr.size() != 0) ? qr[0] : 38'd0));
    endtask

    task automatic quiet_all();
        i0.ap_start = 0; i0.ap_continue = 0;
        i3.ap_start = 0; i3.ap_continue = 0;
        ir.ap_start = 0; ir.ap_continue = 0;
    endtask

    initial begin : main
        logic [37:0] a, b, c, e;
        logic [18:0] vin [5];
        logic [18:0] vexp [5];
        vin  = '{19'd0, 19'd1, 19'd8, 19'd9, 19'h7FFFF};
        vexp = '{19'd0, 19'd1, 19'd1, 19'd2, 19'h10000};
        quiet_all();
        i0.scalar_in = '0; i3.scalar_in = '0; ir.scalar_in = '0;

        // Reset state, observed before any clock edge.
        #2;
        chk("rst_done",  64'(i0.ap_done), 64'd0);
        chk("rst_occ",   64'(i0.occupancy), 64'd0);
        chk("rst_ret",   64'(i0.ap_return), 64'd0);
        chk("rst_idle",  64'(i0.ap_idle), 64'd1);
        @(posedge ap_clk);
        @(posedge ap_clk);
        #3;
        ap_rst = 0;

        // First push after reset, default configuration.
        i0.ap_start = 1; i0.scalar_in = {19'd7, 19'd300};
        cycle();
        e = {19'd7, 19'd300};
        chk("r30_ready", 64'(last_ready0), 64'd1);
        chk("r30_done",  64'(i0.ap_done), 64'd1);
        chk("r30_ret",   64'(i0.ap_return), 64'(e));
        chk("r30_occ",   64'(i0.occupancy), 64'd1);
        i0.ap_start = 0; i0.ap_continue = 1;
        cycle();

        // Full buffer refuses a push even alongside a pop.
        a = 38'h0_1234_5678; b = 38'h3_0000_0001; c = 38'h1_ABCD_EF01;
        i0.ap_continue = 0; i0.ap_start = 1; i0.scalar_in = a;
        cycle();
        i0.scalar_in = b;
        cycle();
        i0.scalar_in = c;
        cycle();
        chk("r31_refuse", 64'(last_ready0), 64'd0);
        chk("r31_occ",    64'(i0.occupancy), 64'd2);
        chk("r31_head",   64'(i0.ap_return), 64'(a));
        i0.ap_continue = 1;
        cycle();
        chk("r31_poprefuse", 64'(last_ready0), 64'd0);
        chk("r31_retb",      64'(i0.ap_return), 64'(b));
        i0.ap_continue = 0;
        cycle();
        chk("r31_acceptc", 64'(last_ready0), 64'd1);
        chk("r31_occ2",    64'(i0.occupancy), 64'd2);
        i0.ap_start = 0; i0.ap_continue = 1;
        cycle();
        cycle();
        chk("r31_empty", 64'(i0.ap_return), 64'd0);

        // Simultaneous push and pop at occupancy 1.
        i0.ap_continue = 0; i0.ap_start = 1; i0.scalar_in = a;
        cycle();
        i0.ap_continue = 1; i0.scalar_in = c;
        cycle();
        chk("r34_occ", 64'(i0.occupancy), 64'd1);
        chk("r34_ret", 64'(i0.ap_return), 64'(c));
        i0.ap_start = 0;
        cycle();

        // Ceiling shift by 3 on boundary values.
        quiet_all();
        for (int i = 0; i < 5; i++) begin
            ir.ap_start = 1; ir.ap_continue = 0;
            ir.scalar_in = {vin[4-i], vin[i]};
            cycle();
            chk("r33_ch0", 64'(ir.ap_return[18:0]),  64'(vexp[i]));
            chk("r33_ch1", 64'(ir.ap_return[37:19]), 64'(vexp[4-i]));
            ir.ap_start = 0; ir.ap_continue = 1;
            cycle();
        end

        // Asynchronous reset with two tasks buffered.
        quiet_all();
        i0.ap_start = 1; i0.scalar_in = a;
        cycle();
        i0.scalar_in = b;
        cycle();
        i0.ap_start = 0;
        #2;
        ap_rst = 1;
        #1;
        chk("r35_done", 64'(i0.ap_done), 64'd0);
        chk("r35_ret",  64'(i0.ap_return), 64'd0);
        chk("r35_occ",  64'(i0.occupancy), 64'd0);
        chk("r35_idle", 64'(i0.ap_idle), 64'd1);
        q0.delete(); q3.delete(); qr.delete();
        i0.ap_start = 1; i0.scalar_in = c;
        @(posedge ap_clk);
        #1;
        chk("r28_nocap", 64'(i0.occupancy), 64'd0);
        ap_rst = 0;
        cycle();
        chk("r29_first", 64'(i0.ap_return), 64'(c));
        i0.ap_start = 0; i0.ap_continue = 1;
        cycle();

        // Random start/continue stalls on all instances.
        for (int n = 0; n < 80; n++) begin
            i0.ap_start = 1'($urandom_range(0, 1)); i0.ap_continue = 1'($urandom_range(0, 1));
            i3.ap_start = 1'($urandom_range(0, 1)); i3.ap_continue = 1'($urandom_range(0, 1));
            ir.ap_start = 1'($urandom_range(0, 1)); ir.ap_continue = 1'($urandom_range(0, 1));
            i0.scalar_in = {6'($urandom), $urandom};
            i3.scalar_in = {6'($urandom), $urandom};
            ir.scalar_in = {6'($urandom), $urandom};
            cycle();
        end
        quiet_all();
        i0.ap_continue = 1; i3.ap_continue = 1; ir.ap_continue = 1;
        for (int n = 0; n < 4; n++) cycle();
        chk("d3_tasks", 64'(pops3 >= 10), 64'd1);
        chk("d3_drained", 64'(i3.occupancy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
